mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, data word width.
REQ-002 Parameter: ADDR_W, default 9, word address width of the shared data memory.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1, rising-edge clock; port reset, input, 1, asynchronous active-high reset.
REQ-004 Requester ports (n = 0 core, n = 1 DMA):
- rn_req, input, 1, access request
- rn_we, input, 1, 1 = write, 0 = read
- rn_addr, input, ADDR_W, word address
- rn_wdata, input, DATA_W, write data
- rn_gnt, output, 1, grant pulse
- rn_rvalid, output, 1, read-data-valid pulse
- rn_rdata, output, DATA_W, read data
REQ-005 Memory-side ports:
- wr, output, 1, memory write strobe
- rd, output, 1, memory read strobe
- addr, output, ADDR_W, memory address
- wr_data, output, DATA_W, memory write data
- rd_data, input, DATA_W, memory read data, valid one cycle after rd
REQ-006 Status port: busy, output, 1, high when state is not IDLE.

Function
REQ-007 States SHALL be IDLE, ISSUE and RESP.
REQ-008 Arbitration SHALL occur in IDLE and in RESP; if any rn_req=1, the block SHALL latch the winner id, we, addr and wdata, then go to ISSUE next cycle; otherwise it SHALL go to IDLE.
REQ-009 In ISSUE, the block SHALL drive the following for exactly one cycle, then go to RESP:
- addr = latched address
- wr = latched we
- rd = !latched we
- wr_data = latched wdata
- winner's rn_gnt = 1
REQ-010 Outside ISSUE, wr, rd and all rn_gnt SHALL be 0; addr and wr_data SHALL hold their last driven values.
REQ-011 In RESP after a read, the block SHALL register rd_data into the winner's rn_rdata and pulse that requester's rn_rvalid for one cycle (the cycle after RESP). After a write, no rvalid.
REQ-012 rn_rdata SHALL hold its value until the next read completion for that requester.
REQ-013 Latency SHALL be: request seen in arbitration cycle T -> gnt at T+1 -> rvalid at T+3. Sustained throughput SHALL be one access per 2 cycles.
REQ-014 A requester SHALL hold rn_req and its fields stable until it sees rn_gnt. The block SHALL ignore rn_req in the cycle rn_gnt is high for that requester; a requester SHALL deassert req the cycle after gnt or have the request treated as a new access.
REQ-015 Simultaneous r0_req and r1_req SHALL resolve per REQ-020/REQ-021; the loser SHALL wait without loss of its request.
REQ-016 A request dropped before grant SHALL be ignored.
REQ-017 rn_gnt and rn_rvalid SHALL never be high for both requesters in the same cycle.

Reset
REQ-018 On reset assertion, the block SHALL asynchronously force:
- state = IDLE
- wr, rd, rn_gnt, rn_rvalid, busy = 0
- addr, wr_data, rn_rdata = 0
- round-robin pointer = requester 0
REQ-019 Reset mid-access (ISSUE or RESP) SHALL abort it with no rvalid. After reset release, the first arbitration SHALL occur on the first clk edge with a request present.

Configuration
REQ-020 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not granted last SHALL win, and the pointer SHALL update on each grant.
REQ-021 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 (core) always winning ties, and no pointer register SHALL exist.

Structure
REQ-022 Package mem_arb_pkg SHALL hold:
- state enum (IDLE, ISSUE, RESP)
- requester-id typedef
- constants NUM_REQ = 2, DEF_ADDR_W = 9, DEF_DATA_W = 32
REQ-023 Sub-module arb_pick SHALL contain the winner selection and pointer logic, including the MEM_ARB_RR_EN variants. mem_arbiter SHALL instantiate it once.

Verification
REQ-024 Single read: r0 read addr 0x012, memory returns 0xDEADBEEF -> rd=1 and addr=0x012 at T+1, r0_gnt at T+1, r0_rvalid=1 and r0_rdata=0xDEADBEEF at T+3.
REQ-025 Single write: r1 write addr 0x1FF, data 0x0000_00A5 -> wr=1, addr=0x1FF, wr_data=0xA5 at T+1, r1_gnt at T+1, no rvalid.
REQ-026 Contention with MEM_ARB_RR_EN: both req held for 6 cycles -> grants alternate r0, r1, r0 at 2-cycle spacing.
REQ-027 Contention without MEM_ARB_RR_EN: both req held -> r0 granted every access while it stays requesting; r1 granted only after r0 deasserts.
REQ-028 Reset mid-access: assert reset during RESP of an r0 read -> outputs zero immediately, no r0_rvalid, busy=0; a new request after release completes normally.
REQ-029 Back-to-back: r0 read 0x001 then write 0x002 with no idle -> gnts 2 cycles apart, busy stays high throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
//   state_t   : arbiter FSM states (IDLE, ISSUE, RESP)
//   req_id_t  : requester id (0 = core, 1 = DMA)
//   NUM_REQ, DEF_ADDR_W, DEF_DATA_W : sizing constants
package mem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: winner selection for the two-requester memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin; ptr_q names the requester that wins the next tie
//               and moves to the other requester on every accepted grant.
//   undefined : fixed priority, requester 0 wins ties, no state at all.
// Ports:
//   clk, reset : clock / async active-high reset (round-robin build only)
//   take       : an arbitration is being accepted this cycle (round-robin only)
//   req        : request vector, bit n = requester n
//   win        : id of the selected requester (don't-care when req == 0)
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               take,
`endif
    input  logic [NUM_REQ-1:0] req,
    output req_id_t            win
);

`ifdef MEM_ARB_RR_EN
    req_id_t ptr_q, ptr_d;

    always_comb begin
        win = ptr_q;
        if (req[0] && !req[1])
            win = 1'b0;
        else if (req[1] && !req[0])
            win = 1'b1;
        // After a grant the other requester gets priority on the next tie.
        ptr_d = take ? ~win : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between a core (r0) and a
// DMA engine (r1). One access per two cycles: arbitrate (IDLE/RESP) ->
// ISSUE (strobe + grant) -> RESP (read data captured, next arbitration).
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
// Ports:
//   clk, reset                  : clock, async active-high reset
//   rN_req/we/addr/wdata        : requester N access request and fields
//   rN_gnt                      : one-cycle grant (ISSUE cycle)
//   rN_rvalid/rN_rdata          : read completion pulse and held read data
//   wr, rd, addr, wr_data       : memory strobes, address and write data
//   rd_data                     : memory read data, valid the cycle after rd
//   busy                        : FSM not in IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    state_t                           state_q, state_d;
    req_id_t                          id_q, id_d;
    logic                             we_q, we_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [DATA_W-1:0]                wdata_q, wdata_d;
    logic [NUM_REQ-1:0]               gnt_q, gnt_d;
    logic                             wr_q, wr_d;
    logic                             rd_q, rd_d;
    logic [NUM_REQ-1:0]               rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0] req_v;
    logic               take;
    req_id_t            win;

    assign req_v = {r1_req, r0_req};
    // Requests are only looked at outside ISSUE, so a requester still holding
    // req during its grant cycle is not double-counted.
    assign take  = (state_q != ISSUE) && (|req_v);

    arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk   (clk),
        .reset (reset),
        .take  (take),
`endif
        .req   (req_v),
        .win   (win)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = '0;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        rvalid_d = '0;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE, RESP: state_d = take ? ISSUE : IDLE;
            ISSUE:      state_d = RESP;
            default:    state_d = IDLE;
        endcase

        // Read completion: memory data is valid during RESP.
        if (state_q == RESP && !we_q) begin
            rvalid_d[id_q] = 1'b1;
            rdata_d[id_q]  = rd_data;
        end

        // Latch the winner; its strobes and grant appear next cycle (ISSUE).
        // addr_q/wdata_q double as the memory-side outputs, so they hold
        // their last driven value until the next grant.
        if (take) begin
            id_d        = win;
            we_d        = win[0] ? r1_we    : r0_we;
            addr_d      = win[0] ? r1_addr  : r0_addr;
            wdata_d     = win[0] ? r1_wdata : r0_wdata;
            gnt_d[win]  = 1'b1;
            wr_d        = we_d;
            rd_d        = !we_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            id_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign r0_gnt    = gnt_q[0];
    assign r1_gnt    = gnt_q[1];
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign r0_rdata  = rdata_q[0];
    assign r1_rdata  = rdata_q[1];
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign wr_data   = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A behavioural memory
// answers rd/wr; read expectations are pushed per requester at grant time
// from a reference memory and popped when rvalid arrives.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          wr, rd, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data = '0;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rv_cyc0 = -1;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    int gnt_log[$];
    int gnt_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: read data valid the cycle after rd.
    always @(posedge clk) begin
        if (wr) mem[addr] <= wr_data;
        if (rd) rd_data <= mem[addr];
    end

    always @(posedge clk) cyc++;

    // Output monitor, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (r0_gnt || r1_gnt) chk("gnt exclusive", {r0_gnt, r1_gnt}, (r0_gnt ? 2'b10 : 2'b01));
        if (r0_rvalid || r1_rvalid) chk("rvalid exclusive", r0_rvalid & r1_rvalid, 0);
        if (r0_rvalid) begin
            rv_cyc0 = cyc;
            if (sb0.size() == 0) chk("r0 unexpected rvalid", r0_rvalid, 0);
            else chk("r0 rdata", r0_rdata, sb0.pop_front());
        end
        if (r1_rvalid) begin
            if (sb1.size() == 0) chk("r1 unexpected rvalid", r1_rvalid, 0);
            else chk("r1 rdata", r1_rdata, sb1.pop_front());
        end
    end

    // Drive one access, wait (bounded) for its grant, drop req, check the bus.
    task automatic issue(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit bz, output int gc, output int lat);
        int sc;
        logic g;
        @(negedge clk);
        sc = cyc;
        if (id == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
        else         begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
        gc = -1;
        g = 1'b0;
        for (int i = 0; i < 20 && gc < 0; i++) begin
            @(posedge clk); #1;
            g = (id == 0) ? r0_gnt : r1_gnt;
            if (g) begin
                gc = cyc;
                if (id == 0) r0_req = 0; else r1_req = 0;
                gnt_log.push_back(id);
                gnt_cyc.push_back(cyc);
                chk("issue addr", addr, a);
                chk("issue wr", wr, we);
                chk("issue rd", rd, !we);
                chk("issue busy", busy, 1);
                if (we) begin
                    chk("issue wr_data", wr_data, d);
                    ref_mem[a] = d;
                end else if (id == 0) sb0.push_back(ref_mem[a]);
                else sb1.push_back(ref_mem[a]);
            end else if (bz) chk("busy between accesses", busy, 1);
        end
        if (gc < 0) begin
            chk("gnt within bound", g, 1);
            if (id == 0) r0_req = 0; else r1_req = 0;
        end
        lat = gc - sc;
    endtask

    initial begin
        int gc, lat, gc2;
        int exp_seq [6];
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc, lat, gc2, lat2;
        int exp_seq [6];
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = i * 32'h9E3779B9;
            ref_mem[i] = i * 32'h9E3779B9;
        end
        mem[9'h012]     = 32'hDEADBEEF;
        ref_mem[9'h012] = 32'hDEADBEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst wr", wr, 0);
        chk("rst rd", rd, 0);
        chk("rst addr", addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst gnt", {r0_gnt, r1_gnt}, 0);
        chk("rst rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("rst rdata", {r0_rdata, r1_rdata}, 0);
        chk("rst busy", busy, 0);
        @(negedge clk) reset = 0;

        // Single read
        issue(0, 0, 9'h012, '0, 0, gc, lat);
        chk("read gnt latency", lat, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("read rvalid latency", rv_cyc0, gc + 2);
        chk("read rdata", r0_rdata, 32'hDEADBEEF);
        @(posedge clk); #2;
        chk("rvalid one cycle", r0_rvalid, 0);
        chk("rdata held", r0_rdata, 32'hDEADBEEF);
        chk("idle busy", busy, 0);

        // Single write (monitor flags any rvalid)
        issue(1, 1, 9'h1FF, 32'h0000_00A5, 0, gc, lat);
        chk("write gnt latency", lat, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("write addr held", addr, 9'h1FF);
        chk("write wr_data held", wr_data, 32'hA5);

        // Contention
        gnt_log.delete();
        gnt_cyc.delete();
        fork
            begin
                int g0, l0;
                for (int k = 0; k < 3; k++) issue(0, 0, 9'(32'h20 + k), '0, 0, g0, l0);
            end
            begin
                int g1, l1;
                for (int k = 0; k < 3; k++) issue(1, 0, 9'(32'h40 + k), '0, 0, g1, l1);
            end
        join
`ifdef MEM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1};
`endif
        chk("contention grants", gnt_log.size(), 6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
            chk("contention order", gnt_log[k], exp_seq[k]);
            if (k > 0) chk("contention spacing", gnt_cyc[k] - gnt_cyc[k-1], 2);
        end
        repeat (4) @(posedge clk);

        // Reset during RESP of an r0 read
        issue(0, 0, 9'h033, '0, 0, gc, lat);
        @(posedge clk); #3;
        reset = 1;
        #1;
        sb0.delete();
        chk("mid-rst rvalid", r0_rvalid, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst addr", addr, 0);
        chk("mid-rst rdata", r0_rdata, 0);
        chk("mid-rst rd/wr", {rd, wr}, 0);
        @(posedge clk);
        @(negedge clk) reset = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("post-rst no rvalid", r0_rvalid, 0);
        rv_cyc0 = -1;
        issue(0, 0, 9'h034, '0, 0, gc, lat);
        chk("post-rst gnt latency", lat, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("post-rst rvalid latency", rv_cyc0, gc + 2);

        // Back-to-back read then write
        repeat (2) @(posedge clk);
        issue(0, 0, 9'h001, '0, 0, gc, lat);
        issue(0, 1, 9'h002, 32'h1234_5678, 1, gc2, lat2);
        chk("b2b gnt spacing", gc2 - gc, 2);
        @(posedge clk); #2;
        chk("b2b busy resp", busy, 1);
        issue(0, 0, 9'h002, '0, 0, gc, lat);
        repeat (4) @(posedge clk);
        #2;

        chk("sb0 drained", sb0.size(), 0);
        chk("sb1 drained", sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
